// File: rtl/tick_timer.sv
// Tick-counting timeout timer driven by an upstream counter's terminal-count pulse.
// Define TICK_TIMER_AUTORELOAD_EN to reload from the last started period on each expiry.
module tick_timer #(
  parameter int unsigned LEN = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           start,
  input  logic           stop,
  input  logic [LEN-1:0] period,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic           done_d;
  logic [LEN-1:0] rem_d;

`ifdef TICK_TIMER_AUTORELOAD_EN
  logic [LEN-1:0] period_q, period_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) period_q <= '0;
    else      period_q <= period_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      state_q   <= state_d;
      done      <= done_d;
      remaining <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    rem_d   = remaining;
`ifdef TICK_TIMER_AUTORELOAD_EN
    period_d = period_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (period != '0) begin
            state_d = RUN;
            rem_d   = period;
`ifdef TICK_TIMER_AUTORELOAD_EN
            period_d = period;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (start) begin
          // A restart with a zero period behaves as a zero-period start from IDLE.
          if (period != '0) begin
            rem_d = period;
`ifdef TICK_TIMER_AUTORELOAD_EN
            period_d = period;
`endif
          end else begin
            state_d = IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end
        end else if (tick) begin
          // Treating 0 like 1 keeps remaining from ever wrapping.
          if (remaining <= LEN'(1)) begin
            done_d = 1'b1;
`ifdef TICK_TIMER_AUTORELOAD_EN
            rem_d = period_q;
`else
            rem_d   = '0;
            state_d = IDLE;
`endif
          end else begin
            rem_d = remaining - LEN'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_tick_timer.sv
// Directed table-driven bench for tick_timer plus hand-written reset and timing sequences.
module tb_tick_timer;

  localparam int unsigned LEN = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           tick, start, stop;
  logic [LEN-1:0] period;
  logic           busy, done;
  logic [LEN-1:0] remaining;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic           start;
    logic           stop;
    logic           tick;
    logic [LEN-1:0] period;
    logic           busy;
    logic           done;
    logic [LEN-1:0] rem;
  } vec_t;

  vec_t vecs[$];

  tick_timer #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic s, input logic p, input logic t, input int per,
                              input logic b, input logic d, input int r);
    vec_t v;
    v.start = s; v.stop = p; v.tick = t; v.period = LEN'(per);
    v.busy = b; v.done = d; v.rem = LEN'(r);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic b, input logic d, input logic [LEN-1:0] r);
    checks++;
    if (busy !== b || done !== d || remaining !== r) begin
      errors++;
      $display("FAIL %s: got busy=%0b done=%0b remaining=%0d, want busy=%0b done=%0b remaining=%0d",
               name, busy, done, remaining, b, d, r);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic t, input logic [LEN-1:0] per);
    @(negedge clk);
    start = s; stop = p; tick = t; period = per;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; period = '0;
    #12;
    check("reset_state", 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;

`ifndef TICK_TIMER_AUTORELOAD_EN
    add(0,0,1,0, 0,0,0);                       // tick in IDLE ignored
    add(1,0,0,3, 1,0,3);                       // one-shot P=3, ticks every 4 cycles
    add(0,0,0,0, 1,0,3); add(0,0,0,0, 1,0,3); add(0,0,0,0, 1,0,3);
    add(0,0,1,0, 1,0,2);
    add(0,0,0,0, 1,0,2); add(0,0,0,0, 1,0,2); add(0,0,0,0, 1,0,2);
    add(0,0,1,0, 1,0,1);
    add(0,0,0,0, 1,0,1); add(0,0,0,0, 1,0,1); add(0,0,0,0, 1,0,1);
    add(0,0,1,0, 0,1,0);                       // expiry
    add(0,0,0,0, 0,0,0);                       // done only one cycle
    add(1,0,0,0, 0,1,0);                       // zero period
    add(0,0,0,0, 0,0,0);
    add(1,0,0,5, 1,0,5);                       // abort at remaining=2
    add(0,0,1,0, 1,0,4); add(0,0,1,0, 1,0,3); add(0,0,1,0, 1,0,2);
    add(0,1,0,0, 0,0,0);
    add(0,0,1,0, 0,0,0);
    add(1,0,0,2, 1,0,2);                       // start+stop in RUN
    add(1,1,0,7, 0,0,0);
    add(1,1,0,3, 0,0,0);                       // start+stop in IDLE
    add(1,0,0,6, 1,0,6);                       // start+tick in RUN
    add(0,0,1,0, 1,0,5);
    add(1,0,1,4, 1,0,4);
    add(0,0,1,0, 1,0,3);
    add(0,1,0,0, 0,0,0);
    add(1,0,0,1, 1,0,1);                       // back-to-back
    add(0,0,1,0, 0,1,0);
    add(1,0,0,1, 1,0,1);
    add(0,0,1,0, 0,1,0);
    add(0,0,0,0, 0,0,0);
`else
    add(1,0,0,2, 1,0,2);                       // autoreload P=2, 6 ticks
    add(0,0,1,0, 1,0,1); add(0,0,1,0, 1,1,2);
    add(0,0,1,0, 1,0,1); add(0,0,1,0, 1,1,2);
    add(0,0,1,0, 1,0,1); add(0,0,1,0, 1,1,2);
    add(0,0,0,0, 1,0,2);
    add(0,1,0,0, 0,0,0);
    add(1,0,0,0, 0,1,0);                       // zero period still single pulse
    add(0,0,0,0, 0,0,0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].stop, vecs[i].tick, vecs[i].period);
      check($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done, vecs[i].rem);
    end

    // Asynchronous reset mid-count, away from any clock edge.
    step(1'b1, 1'b0, 1'b0, LEN'(5));
    check("pre_reset_run", 1'b1, 1'b0, LEN'(5));
    @(negedge clk);
    start = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, '0);
    check("post_reset_1", 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    check("post_reset_2", 1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
